// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and state encoding for the SPI frame receiver
package spi_pkg;
    localparam int FRAME_W = 81;
    localparam int PAYLOAD_W = 57;
    localparam logic [15:0] HDR_VAL = 16'h55AB;
    localparam logic [7:0] TRL_VAL = 8'hAA;
    localparam int PAY_HI = 64;
    localparam int PAY_LO = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DRAIN} state_t;
endpackage

// File: rtl/spi_payload_fifo.sv
// spi_payload_fifo: small synchronous FIFO holding accepted frame payloads
module spi_payload_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 57
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout = empty ? '0 : mem[rp[AW-1:0]];
    // Pointers carry a wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(push && !full);
            rp <= rp + (AW+1)'(pop && !empty);
        end
    end
    // Storage needs no reset; dout is masked while empty
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: oversampling SPI frame receiver with framing checks and payload FIFO
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_W = spi_pkg::FRAME_W,
    parameter logic [15:0] HDR = spi_pkg::HDR_VAL,
    parameter logic [7:0] TRL = spi_pkg::TRL_VAL,
    parameter int TO_CYC = 1024,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sck,
    input  logic                 cs,
    input  logic                 sdi,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     len_err_cnt,
    output logic [CNT_W-1:0]     fmt_err_cnt,
    output logic [CNT_W-1:0]     to_err_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    input  logic                 err_clr
);
    localparam int TW = $clog2(TO_CYC);
    logic [2:0] sck_q;
    logic [1:0] cs_q, sdi_q;
    logic cs_s, sdi_s, sck_rise;
    state_t state;
    logic [FRAME_W-1:0] sr;
    logic [6:0] cnt;
    logic [TW-1:0] to_cnt;
    logic full, empty, match, full_len, to_hit, push;
    logic len_inc, fmt_inc, to_inc, drop_inc;
    assign cs_s = cs_q[1];
    assign sdi_s = sdi_q[1];
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign match = (sr[FRAME_W-1 -: 16] == HDR) && (sr[7:0] == TRL);
    assign full_len = cnt == 7'(FRAME_W);
    assign to_hit = to_cnt == TW'(TO_CYC - 1);
    assign push = (state == CHECK) && match && !full;
    assign busy = state != IDLE;
    assign out_valid = !empty;
    assign len_inc = (state == SHIFT) && (cs_s ? !full_len : sck_rise && full_len);
    assign to_inc = (state == SHIFT) && !cs_s && !sck_rise && to_hit;
    assign fmt_inc = (state == CHECK) && !match;
    assign drop_inc = (state == CHECK) && match && full;
    // Two-flop synchronisers; the extra sck flop gives rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q <= '0;
            cs_q <= '1;
            sdi_q <= '0;
        end else begin
            sck_q <= {sck_q[1:0], sck};
            cs_q <= {cs_q[0], cs};
            sdi_q <= {sdi_q[0], sdi};
        end
    end
    // Frame sequencer: chip-select release wins over a coincident sck edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (!cs_s) begin
                    sr <= '0;
                    cnt <= '0;
                    to_cnt <= '0;
                    state <= SHIFT;
                end
                SHIFT: if (cs_s) state <= full_len ? CHECK : IDLE;
                else if (sck_rise) begin
                    if (full_len) state <= DRAIN;
                    else begin
                        sr <= {sr[FRAME_W-2:0], sdi_s};
                        cnt <= cnt + 7'd1;
                        to_cnt <= '0;
                    end
                end else if (to_hit) state <= DRAIN;
                else to_cnt <= to_cnt + TW'(1);
                CHECK: state <= IDLE;
                default: if (cs_s) state <= IDLE;
            endcase
        end
    end
    // Saturating error counters; clear overrides any same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_err_cnt <= '0;
            fmt_err_cnt <= '0;
            to_err_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            len_err_cnt <= err_clr ? '0 : len_err_cnt + CNT_W'(len_inc && !(&len_err_cnt));
            fmt_err_cnt <= err_clr ? '0 : fmt_err_cnt + CNT_W'(fmt_inc && !(&fmt_err_cnt));
            to_err_cnt <= err_clr ? '0 : to_err_cnt + CNT_W'(to_inc && !(&to_err_cnt));
            drop_cnt <= err_clr ? '0 : drop_cnt + CNT_W'(drop_inc && !(&drop_cnt));
        end
    end
    spi_payload_fifo #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(sr[PAY_HI:PAY_LO]),
        .pop(out_valid && out_ready),
        .dout(out_data),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed self-checking bench for spi_frame_ctrl
module tb_spi_frame_ctrl;
    localparam int CW = 5;
    localparam logic [56:0] P0 = 57'h0123456789ABCDE;
    localparam logic [56:0] P1 = 57'h1111111_22222222;
    localparam logic [56:0] P2 = 57'h0ABCDEF_01234567;
    localparam logic [56:0] P3 = 57'h1555555_55555555;
    logic clk = 0, rst = 1, sck = 0, cs = 1, sdi = 0, out_ready = 0, err_clr = 0;
    logic [56:0] out_data;
    logic out_valid, busy;
    logic [CW-1:0] len_err_cnt, fmt_err_cnt, to_err_cnt, drop_cnt;
    int errors = 0, checks = 0, vcyc = 0;
    logic [56:0] got[$];

    spi_frame_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs), .sdi(sdi),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .len_err_cnt(len_err_cnt), .fmt_err_cnt(fmt_err_cnt), .to_err_cnt(to_err_cnt),
        .drop_cnt(drop_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) vcyc++;
        if (out_valid && out_ready) got.push_back(out_data);
    end

    function automatic logic [80:0] mk(input logic [15:0] h, input logic [56:0] p, input logic [7:0] t);
        return {h, p, t};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        cs = 0;
        tick(6);
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        tick(4);
        sck = 1;
        tick(4);
        sck = 0;
    endtask

    task automatic end_frame();
        tick(4);
        cs = 1;
        tick(8);
    endtask

    task automatic send_frame(input logic [127:0] v, input int n);
        start_frame();
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
        end_frame();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 57'h0) begin errors++; $display("FAIL rst_data: got %0h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if ({len_err_cnt, fmt_err_cnt, to_err_cnt, drop_cnt} !== '0) begin errors++; $display("FAIL rst_cnts: got %0h expected 0", {len_err_cnt, fmt_err_cnt, to_err_cnt, drop_cnt}); end
        rst = 0;
        tick(3);
    endtask

    task automatic test_good();
        int v0, n0;
        v0 = vcyc;
        n0 = got.size();
        out_ready = 1;
        send_frame({47'b0, mk(16'h55AB, P0, 8'hAA)}, 81);
        checks++; if (got.size() !== n0 + 1) begin errors++; $display("FAIL good_count: got %0d expected %0d", got.size(), n0 + 1); end
        else begin checks++; if (got[n0] !== P0) begin errors++; $display("FAIL good_data: got %0h expected %0h", got[n0], P0); end end
        checks++; if (vcyc - v0 !== 1) begin errors++; $display("FAIL good_pulse: got %0d expected 1", vcyc - v0); end
        checks++; if ({len_err_cnt, fmt_err_cnt, to_err_cnt, drop_cnt} !== '0) begin errors++; $display("FAIL good_cnts: got %0h expected 0", {len_err_cnt, fmt_err_cnt, to_err_cnt, drop_cnt}); end
    endtask

    task automatic test_length();
        logic [80:0] f;
        int n0;
        n0 = got.size();
        f = mk(16'h55AB, P0, 8'hAA);
        send_frame({48'b0, f[80:1]}, 80);
        checks++; if (len_err_cnt !== 1) begin errors++; $display("FAIL short_len: got %0d expected 1", len_err_cnt); end
        start_frame();
        for (int i = 80; i >= 0; i--) send_bit(f[i]);
        send_bit(1'b0);
        tick(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL over_drain_busy: got %b expected 1", busy); end
        checks++; if (len_err_cnt !== 2) begin errors++; $display("FAIL over_len: got %0d expected 2", len_err_cnt); end
        end_frame();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL over_idle: got %b expected 0", busy); end
        checks++; if (got.size() !== n0) begin errors++; $display("FAIL len_nowrite: got %0d expected %0d", got.size(), n0); end
        checks++; if (fmt_err_cnt !== 0) begin errors++; $display("FAIL len_fmt: got %0d expected 0", fmt_err_cnt); end
    endtask

    task automatic test_format();
        int v0;
        v0 = vcyc;
        send_frame({47'b0, mk(16'h55AC, P0, 8'hAA)}, 81);
        checks++; if (fmt_err_cnt !== 1) begin errors++; $display("FAIL bad_hdr: got %0d expected 1", fmt_err_cnt); end
        send_frame({47'b0, mk(16'h55AB, P0, 8'hAB)}, 81);
        checks++; if (fmt_err_cnt !== 2) begin errors++; $display("FAIL bad_trl: got %0d expected 2", fmt_err_cnt); end
        checks++; if (vcyc !== v0) begin errors++; $display("FAIL fmt_novalid: got %0d expected %0d", vcyc, v0); end
        checks++; if (len_err_cnt !== 2) begin errors++; $display("FAIL fmt_len: got %0d expected 2", len_err_cnt); end
    endtask

    task automatic test_backpressure();
        int n0;
        n0 = got.size();
        out_ready = 0;
        send_frame({47'b0, mk(16'h55AB, P1, 8'hAA)}, 81);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== P1) begin errors++; $display("FAIL bp_data1: got %0h expected %0h", out_data, P1); end
        send_frame({47'b0, mk(16'h55AB, P2, 8'hAA)}, 81);
        send_frame({47'b0, mk(16'h55AB, P3, 8'hAA)}, 81);
        checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL bp_drop: got %0d expected 1", drop_cnt); end
        checks++; if (out_data !== P1) begin errors++; $display("FAIL bp_stable: got %0h expected %0h", out_data, P1); end
        out_ready = 1;
        tick(4);
        checks++; if (got.size() !== n0 + 2) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got.size(), n0 + 2); end
        else begin
            checks++; if (got[n0] !== P1) begin errors++; $display("FAIL bp_first: got %0h expected %0h", got[n0], P1); end
            checks++; if (got[n0+1] !== P2) begin errors++; $display("FAIL bp_second: got %0h expected %0h", got[n0+1], P2); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_timeout();
        int n0;
        start_frame();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        tick(1100);
        checks++; if (to_err_cnt !== 1) begin errors++; $display("FAIL to_cnt: got %0d expected 1", to_err_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_drain: got %b expected 1", busy); end
        end_frame();
        checks++; if (len_err_cnt !== 2) begin errors++; $display("FAIL to_nolen: got %0d expected 2", len_err_cnt); end
        n0 = got.size();
        send_frame({47'b0, mk(16'h55AB, P3, 8'hAA)}, 81);
        checks++; if (got.size() !== n0 + 1) begin errors++; $display("FAIL to_recover: got %0d expected %0d", got.size(), n0 + 1); end
        else begin checks++; if (got[n0] !== P3) begin errors++; $display("FAIL to_data: got %0h expected %0h", got[n0], P3); end end
    endtask

    task automatic test_rst_mid_frame();
        logic [80:0] f;
        int n0;
        out_ready = 0;
        send_frame({47'b0, mk(16'h55AB, P2, 8'hAA)}, 81);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %b expected 1", out_valid); end
        f = mk(16'h55AB, P1, 8'hAA);
        start_frame();
        for (int i = 80; i > 40; i--) send_bit(f[i]);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_pre_busy: got %b expected 1", busy); end
        #3 rst = 1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", out_valid); end
        checks++; if (to_err_cnt !== 0) begin errors++; $display("FAIL mrst_cnt: got %0d expected 0", to_err_cnt); end
        cs = 1;
        sck = 0;
        tick(2);
        rst = 0;
        tick(4);
        out_ready = 1;
        n0 = got.size();
        send_frame({47'b0, mk(16'h55AB, P1, 8'hAA)}, 81);
        checks++; if (got.size() !== n0 + 1) begin errors++; $display("FAIL mrst_next: got %0d expected %0d", got.size(), n0 + 1); end
        else begin checks++; if (got[n0] !== P1) begin errors++; $display("FAIL mrst_data: got %0h expected %0h", got[n0], P1); end end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 35; k++) send_frame({47'b0, mk(16'h55AB, P0, 8'h00)}, 81);
        checks++; if (fmt_err_cnt !== {CW{1'b1}}) begin errors++; $display("FAIL sat_fmt: got %0d expected %0d", fmt_err_cnt, {CW{1'b1}}); end
        checks++; if (len_err_cnt !== 0) begin errors++; $display("FAIL sat_len: got %0d expected 0", len_err_cnt); end
    endtask

    task automatic test_err_clr();
        err_clr = 1;
        send_frame({47'b0, mk(16'hAAAA, P0, 8'hAA)}, 81);
        err_clr = 0;
        tick(1);
        checks++; if (fmt_err_cnt !== 0) begin errors++; $display("FAIL clr_fmt: got %0d expected 0", fmt_err_cnt); end
        send_frame({47'b0, mk(16'hAAAA, P0, 8'hAA)}, 81);
        checks++; if (fmt_err_cnt !== 1) begin errors++; $display("FAIL clr_after: got %0d expected 1", fmt_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_length();
        test_format();
        test_backpressure();
        test_timeout();
        test_rst_mid_frame();
        test_saturate();
        test_err_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
